// File: rtl/gpu_pkg.sv
// Shared definitions for the 2D GPU frame-buffer blocks.
package gpu_pkg;

  localparam int PIX_BITS      = 24;
  localparam int PIX_PER_WORD  = 64;
  localparam int WORD_BITS     = PIX_BITS * PIX_PER_WORD;
  localparam int ADDR_BITS     = 24;
  localparam int WORDS_PER_ROW = (640 + PIX_PER_WORD - 1) / PIX_PER_WORD;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    READ_REQ,
    READ_WAIT,
    WRITE,
    ADVANCE,
    DONE
  } fill_state_t;

endpackage

// File: rtl/fill_merge.sv
// Combinational pixel merge: colour on pixels lo..hi, read data elsewhere.
module fill_merge #(
  parameter int  PIX_BITS     = 24,
  parameter int  PIX_PER_WORD = 64,
  localparam int IDX_W        = $clog2(PIX_PER_WORD)
) (
  input  logic [IDX_W-1:0]                 lo_i,
  input  logic [IDX_W-1:0]                 hi_i,
  input  logic [PIX_BITS-1:0]              color_i,
  input  logic [PIX_PER_WORD*PIX_BITS-1:0] read_data_i,
  output logic [PIX_PER_WORD*PIX_BITS-1:0] merged_o
);

  // Replace every pixel inside the span with the fill colour.
  always_comb begin
    merged_o = read_data_i;
    for (int unsigned i = 0; i < PIX_PER_WORD; i++) begin
      if (IDX_W'(i) >= lo_i && IDX_W'(i) <= hi_i) begin
        merged_o[i*PIX_BITS +: PIX_BITS] = color_i;
      end
    end
  end

endmodule

// File: rtl/fill_engine.sv
// Rectangle fill engine: walks the covered SRAM words row by row, writing
// full words directly and read-modify-writing partially covered edge words.
module fill_engine #(
  parameter int SCREEN_W     = 640,
  parameter int SCREEN_H     = 480,
  parameter int PIX_PER_WORD = 64,
  parameter int PIX_BITS     = 24
) (
  input  logic                             clk,
  input  logic                             n_rst,
  input  logic                             start,
  input  logic [9:0]                       x0,
  input  logic [9:0]                       x1,
  input  logic [8:0]                       y0,
  input  logic [8:0]                       y1,
  input  logic [PIX_BITS-1:0]              color,
  input  logic                             mem_busy,
  input  logic [PIX_PER_WORD*PIX_BITS-1:0] read_data,
  input  logic                             read_valid,
  output logic                             fill_en,
  output logic                             f_read_enable,
  output logic                             f_write_enable,
  output logic [gpu_pkg::ADDR_BITS-1:0]    f_address,
  output logic [PIX_PER_WORD*PIX_BITS-1:0] f_write_data,
  output logic                             done
);

  import gpu_pkg::*;

  localparam int XW    = 10;
  localparam int YW    = 9;
  localparam int IDX_W = $clog2(PIX_PER_WORD);
  localparam int WB    = PIX_PER_WORD * PIX_BITS;
  localparam int WPR   = (SCREEN_W + PIX_PER_WORD - 1) / PIX_PER_WORD;

  fill_state_t state_q, state_d;

  logic [XW-1:0]       x0_q, x1_q;
  logic [YW-1:0]       y0_q, y1_q;
  logic [PIX_BITS-1:0] color_q;
  logic [XW-1:0]       wx_q, wx_d;
  logic [YW-1:0]       row_q, row_d;

  logic                 fill_en_q, rd_en_q, wr_en_q, done_q;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [WB-1:0]        wdata_q, merged;

  logic [XW-1:0]    wx_first, wx_last;
  logic [IDX_W-1:0] x0_off, x1_off, lo_d, hi_d;
  logic             empty;

  assign wx_first = x0_q / XW'(PIX_PER_WORD);
  assign wx_last  = x1_q / XW'(PIX_PER_WORD);
  assign x0_off   = IDX_W'(x0_q % XW'(PIX_PER_WORD));
  assign x1_off   = IDX_W'(x1_q % XW'(PIX_PER_WORD));
  assign empty    = (x0_q > x1_q) || (y0_q > y1_q) ||
                    (x0_q >= XW'(SCREEN_W)) || (y0_q >= YW'(SCREEN_H));

  // lo/hi and address always describe the word being entered next.
  assign lo_d   = (wx_d == wx_first) ? x0_off : '0;
  assign hi_d   = (wx_d == wx_last) ? x1_off : IDX_W'(PIX_PER_WORD - 1);
  assign addr_d = ADDR_BITS'(row_d) * ADDR_BITS'(WPR) + ADDR_BITS'(wx_d);

  function automatic logic word_full(input logic [XW-1:0] wx);
    return (wx != wx_first || x0_off == '0) &&
           (wx != wx_last  || x1_off == IDX_W'(PIX_PER_WORD - 1));
  endfunction

  fill_merge #(
    .PIX_BITS    (PIX_BITS),
    .PIX_PER_WORD(PIX_PER_WORD)
  ) u_merge (
    .lo_i       (lo_d),
    .hi_i       (hi_d),
    .color_i    (color_q),
    .read_data_i(read_data),
    .merged_o   (merged)
  );

  // Next-state and word-position sequencing.
  always_comb begin
    state_d = state_q;
    wx_d    = wx_q;
    row_d   = row_q;
    unique case (state_q)
      IDLE:      if (start) state_d = SETUP;
      SETUP: begin
        if (empty) begin
          state_d = DONE;
        end else begin
          wx_d    = wx_first;
          row_d   = y0_q;
          state_d = word_full(wx_first) ? WRITE : READ_REQ;
        end
      end
      READ_REQ:  if (!mem_busy) state_d = READ_WAIT;
      READ_WAIT: if (read_valid) state_d = WRITE;
      WRITE:     if (!mem_busy) state_d = ADVANCE;
      ADVANCE: begin
        if (wx_q != wx_last) begin
          wx_d    = wx_q + 1'b1;
          state_d = word_full(wx_q + 1'b1) ? WRITE : READ_REQ;
        end else if (row_q != y1_q) begin
          wx_d    = wx_first;
          row_d   = row_q + 1'b1;
          state_d = word_full(wx_first) ? WRITE : READ_REQ;
        end else begin
          state_d = DONE;
        end
      end
      DONE:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // State, command capture and registered request outputs.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= IDLE;
      x0_q      <= '0;
      x1_q      <= '0;
      y0_q      <= '0;
      y1_q      <= '0;
      color_q   <= '0;
      wx_q      <= '0;
      row_q     <= '0;
      fill_en_q <= 1'b0;
      rd_en_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      done_q    <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else begin
      state_q <= state_d;
      wx_q    <= wx_d;
      row_q   <= row_d;
      if (state_q == IDLE && start) begin
        x0_q    <= x0;
        x1_q    <= (x1 > XW'(SCREEN_W - 1)) ? XW'(SCREEN_W - 1) : x1;
        y0_q    <= y0;
        y1_q    <= (y1 > YW'(SCREEN_H - 1)) ? YW'(SCREEN_H - 1) : y1;
        color_q <= color;
      end
      fill_en_q <= (state_d != IDLE);
      rd_en_q   <= (state_d == READ_REQ);
      wr_en_q   <= (state_d == WRITE);
      done_q    <= (state_d == DONE);
      if (state_d == READ_REQ || state_d == WRITE) addr_q <= addr_d;
      // Data is latched once on WRITE entry, so it stays put under mem_busy.
      if (state_d == WRITE && state_q != WRITE) wdata_q <= merged;
    end
  end

  assign fill_en        = fill_en_q;
  assign f_read_enable  = rd_en_q;
  assign f_write_enable = wr_en_q;
  assign f_address      = addr_q;
  assign f_write_data   = wdata_q;
  assign done           = done_q;

endmodule

// File: tb/tb_fill_engine.sv
// Self-checking bench for fill_engine with an SRAM responder and scoreboard.
module tb_fill_engine;

  typedef struct {
    logic        wr;
    logic [23:0] addr;
    logic [1535:0] data;
  } txn_t;

  localparam int RD_LAT = 2;

  logic          clk, n_rst, start, mem_busy, read_valid;
  logic [9:0]    x0, x1;
  logic [8:0]    y0, y1;
  logic [23:0]   color;
  logic [1535:0] read_data;
  logic          fill_en, f_read_enable, f_write_enable, done;
  logic [23:0]   f_address;
  logic [1535:0] f_write_data;

  int checks = 0;
  int errors = 0;

  txn_t exp_q[$];
  txn_t obs[512];
  int   obs_n = 0;
  int   rd_ptr = 0;
  int   done_seen = 0;
  int   both_seen = 0;

  bit          rsp_pend = 1'b0;
  int          rsp_cnt = 0;
  logic [23:0] rsp_addr = '0;

  fill_engine dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .start         (start),
    .x0            (x0),
    .x1            (x1),
    .y0            (y0),
    .y1            (y1),
    .color         (color),
    .mem_busy      (mem_busy),
    .read_data     (read_data),
    .read_valid    (read_valid),
    .fill_en       (fill_en),
    .f_read_enable (f_read_enable),
    .f_write_enable(f_write_enable),
    .f_address     (f_address),
    .f_write_data  (f_write_data),
    .done          (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM content: a fixed per-address pattern distinct from any fill colour.
  function automatic logic [1535:0] sram_word(input logic [23:0] a);
    logic [1535:0] w;
    for (int p = 0; p < 64; p++) w[p*24 +: 24] = {a[7:0], 8'(p), 8'h5A};
    return w;
  endfunction

  // Monitor: records every accepted request and counts done pulses.
  always @(negedge clk) begin
    if (n_rst) begin
      if (done) done_seen++;
      if (f_read_enable && f_write_enable) both_seen++;
      if ((f_read_enable || f_write_enable) && !mem_busy && obs_n < 512) begin
        obs[obs_n] = '{wr: f_write_enable, addr: f_address, data: f_write_data};
        obs_n++;
      end
    end
  end

  // Responder: returns the addressed word RD_LAT cycles after a read is accepted.
  always @(negedge clk) begin
    read_valid = 1'b0;
    if (!n_rst) begin
      rsp_pend = 1'b0;
    end else begin
      if (rsp_pend) begin
        if (rsp_cnt == 0) begin
          read_valid = 1'b1;
          read_data  = sram_word(rsp_addr);
          rsp_pend   = 1'b0;
        end else begin
          rsp_cnt--;
        end
      end
      if (f_read_enable && !mem_busy) begin
        rsp_pend = 1'b1;
        rsp_cnt  = RD_LAT;
        rsp_addr = f_address;
      end
    end
  end

  // Reference model: pushes the request sequence a command should produce.
  task automatic model_cmd(input int cx0, input int cx1, input int cy0, input int cy1,
                           input logic [23:0] c);
    int xe, ye;
    xe = (cx1 > 639) ? 639 : cx1;
    ye = (cy1 > 479) ? 479 : cy1;
    if (cx0 > xe || cy0 > ye || cx0 >= 640 || cy0 >= 480) return;
    for (int y = cy0; y <= ye; y++) begin
      for (int w = cx0 / 64; w <= xe / 64; w++) begin
        logic [1535:0] d;
        logic [23:0]   a;
        bit            part;
        a    = 24'(y * 10 + w);
        d    = sram_word(a);
        part = 1'b0;
        for (int p = 0; p < 64; p++) begin
          if (w * 64 + p >= cx0 && w * 64 + p <= xe) d[p*24 +: 24] = c;
          else part = 1'b1;
        end
        if (part) exp_q.push_back('{wr: 1'b0, addr: a, data: '0});
        exp_q.push_back('{wr: 1'b1, addr: a, data: d});
      end
    end
  endtask

  task automatic start_cmd(input int cx0, input int cx1, input int cy0, input int cy1,
                           input logic [23:0] c);
    @(posedge clk); #1;
    x0 = 10'(cx0); x1 = 10'(cx1); y0 = 9'(cy0); y1 = 9'(cy1); color = c;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic test_reset;
    n_rst = 1'b1;
    #3 n_rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({fill_en, f_read_enable, f_write_enable, done, |f_address, |f_write_data} !== 6'b0) begin
      errors++;
      $display("FAIL reset outputs: got en=%b rd=%b wr=%b done=%b addr=%0d, required all 0",
               fill_en, f_read_enable, f_write_enable, done, f_address);
    end
    @(posedge clk); #1 n_rst = 1'b1;
  endtask

  task automatic test_full_word;
    txn_t e, o;
    int   d0, n;
    d0 = done_seen;
    model_cmd(0, 127, 0, 0, 24'hFF0000);
    start_cmd(0, 127, 0, 0, 24'hFF0000);
    n = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      n++;
      if (i == 0) begin
        checks++;
        if (fill_en !== 1'b1) begin errors++; $display("FAIL full fill_en rise: got %b, required 1", fill_en); end
      end
      if (done) break;
    end
    checks++;
    if (n != 6) begin errors++; $display("FAIL full latency: got done at cycle %0d, required 6", n); end
    repeat (3) @(negedge clk);
    checks++;
    if (done_seen != d0 + 1 || fill_en !== 1'b0) begin
      errors++; $display("FAIL full done: got %0d pulses fill_en=%b, required 1 pulse fill_en=0", done_seen - d0, fill_en);
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); checks++;
      if (rd_ptr >= obs_n) begin errors++; $display("FAIL full txn: missing, required wr=%0b addr=%0d", e.wr, e.addr); end
      else begin
        o = obs[rd_ptr]; rd_ptr++;
        if (o.wr !== e.wr || o.addr !== e.addr || (e.wr && o.data !== e.data)) begin
          errors++; $display("FAIL full txn: got wr=%0b addr=%0d data[47:0]=%h, required wr=%0b addr=%0d data[47:0]=%h",
                             o.wr, o.addr, o.data[47:0], e.wr, e.addr, e.data[47:0]);
        end
      end
    end
    checks++;
    if (obs_n != rd_ptr) begin errors++; $display("FAIL full extra: got %0d extra requests, required 0", obs_n - rd_ptr); rd_ptr = obs_n; end
  endtask

  task automatic test_partial(input int cx0, input int cx1, input int cy0, input int cy1,
                              input logic [23:0] c);
    txn_t e, o;
    int   d0;
    d0 = done_seen;
    model_cmd(cx0, cx1, cy0, cy1, c);
    start_cmd(cx0, cx1, cy0, cy1, c);
    for (int i = 0; i < 2000 && done_seen == d0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    checks++;
    if (done_seen != d0 + 1) begin errors++; $display("FAIL partial done: got %0d pulses, required 1", done_seen - d0); end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); checks++;
      if (rd_ptr >= obs_n) begin errors++; $display("FAIL partial txn: missing, required wr=%0b addr=%0d", e.wr, e.addr); end
      else begin
        o = obs[rd_ptr]; rd_ptr++;
        if (o.wr !== e.wr || o.addr !== e.addr || (e.wr && o.data !== e.data)) begin
          errors++; $display("FAIL partial txn: got wr=%0b addr=%0d data ok=%0b, required wr=%0b addr=%0d",
                             o.wr, o.addr, o.data === e.data, e.wr, e.addr);
        end
      end
    end
    checks++;
    if (obs_n != rd_ptr) begin errors++; $display("FAIL partial extra: got %0d extra requests, required 0", obs_n - rd_ptr); rd_ptr = obs_n; end
  endtask

  task automatic test_backpressure;
    txn_t          e, o;
    logic [1535:0] w;
    bit            found;
    int            d0;
    d0 = done_seen;
    for (int p = 0; p < 64; p++) w[p*24 +: 24] = 24'h0000FF;
    model_cmd(128, 191, 4, 4, 24'h0000FF);
    @(posedge clk); #1 mem_busy = 1'b1;
    start_cmd(128, 191, 4, 4, 24'h0000FF);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin @(negedge clk); found = f_write_enable; end
    checks++;
    if (!found) begin errors++; $display("FAIL bp write: got no write request, required one"); end
    for (int k = 0; k < 5; k++) begin
      if (k != 0) @(negedge clk);
      checks++;
      if (f_write_enable !== 1'b1 || f_read_enable !== 1'b0 || f_address !== 24'd42 || f_write_data !== w) begin
        errors++; $display("FAIL bp hold %0d: got wr=%b rd=%b addr=%0d, required wr=1 rd=0 addr=42 data stable",
                           k, f_write_enable, f_read_enable, f_address);
      end
      @(posedge clk); #1;
    end
    mem_busy = 1'b0;
    @(negedge clk);
    checks++;
    if (f_write_enable !== 1'b1) begin errors++; $display("FAIL bp issue: got wr=%b, required 1", f_write_enable); end
    @(negedge clk);
    checks++;
    if (f_write_enable !== 1'b0) begin errors++; $display("FAIL bp release: got wr=%b, required 0", f_write_enable); end
    for (int i = 0; i < 100 && done_seen == d0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    checks++;
    if (done_seen != d0 + 1) begin errors++; $display("FAIL bp done: got %0d pulses, required 1", done_seen - d0); end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); checks++;
      if (rd_ptr >= obs_n) begin errors++; $display("FAIL bp txn: missing, required addr=%0d", e.addr); end
      else begin
        o = obs[rd_ptr]; rd_ptr++;
        if (o.wr !== e.wr || o.addr !== e.addr || (e.wr && o.data !== e.data)) begin
          errors++; $display("FAIL bp txn: got wr=%0b addr=%0d, required wr=%0b addr=%0d", o.wr, o.addr, e.wr, e.addr);
        end
      end
    end
    checks++;
    if (obs_n != rd_ptr) begin errors++; $display("FAIL bp extra: got %0d extra requests, required 0", obs_n - rd_ptr); rd_ptr = obs_n; end
  endtask

  task automatic test_empty;
    int ex0[3] = '{20, 640, 0};
    int ex1[3] = '{10, 700, 10};
    int ey0[3] = '{0, 0, 490};
    int ey1[3] = '{0, 0, 500};
    for (int k = 0; k < 3; k++) begin
      start_cmd(ex0[k], ex1[k], ey0[k], ey1[k], 24'h123456);
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || fill_en !== 1'b1) begin
        errors++; $display("FAIL empty%0d setup: got done=%b fill_en=%b, required done=0 fill_en=1", k, done, fill_en);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b1) begin errors++; $display("FAIL empty%0d done: got %b, required 1", k, done); end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || fill_en !== 1'b0) begin
        errors++; $display("FAIL empty%0d idle: got done=%b fill_en=%b, required 0 0", k, done, fill_en);
      end
      checks++;
      if (obs_n != rd_ptr) begin errors++; $display("FAIL empty%0d requests: got %0d, required 0", k, obs_n - rd_ptr); rd_ptr = obs_n; end
    end
  endtask

  task automatic test_start_while_busy;
    txn_t e, o;
    int   d0;
    d0 = done_seen;
    model_cmd(0, 255, 1, 2, 24'hABCDEF);
    start_cmd(0, 255, 1, 2, 24'hABCDEF);
    repeat (3) @(posedge clk);
    #1;
    x0 = 10'd0; x1 = 10'd63; y0 = 9'd0; y1 = 9'd0; color = 24'h111111; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int i = 0; i < 200 && done_seen == d0; i++) @(negedge clk);
    repeat (5) @(negedge clk);
    checks++;
    if (done_seen != d0 + 1) begin errors++; $display("FAIL busy done: got %0d pulses, required 1", done_seen - d0); end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); checks++;
      if (rd_ptr >= obs_n) begin errors++; $display("FAIL busy txn: missing, required addr=%0d", e.addr); end
      else begin
        o = obs[rd_ptr]; rd_ptr++;
        if (o.wr !== e.wr || o.addr !== e.addr || (e.wr && o.data !== e.data)) begin
          errors++; $display("FAIL busy txn: got wr=%0b addr=%0d, required wr=%0b addr=%0d", o.wr, o.addr, e.wr, e.addr);
        end
      end
    end
    checks++;
    if (obs_n != rd_ptr) begin errors++; $display("FAIL busy extra: got %0d extra requests, required 0", obs_n - rd_ptr); rd_ptr = obs_n; end
  endtask

  task automatic test_reset_mid;
    bit found;
    int d0;
    d0 = done_seen;
    start_cmd(10, 20, 3, 3, 24'h00FF00);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin @(negedge clk); found = f_read_enable && !mem_busy; end
    checks++;
    if (!found) begin errors++; $display("FAIL rstmid read: got no read request, required one"); end
    @(posedge clk); #1 n_rst = 1'b0;
    #1;
    checks++;
    if ({fill_en, f_read_enable, f_write_enable, done, |f_address, |f_write_data} !== 6'b0) begin
      errors++; $display("FAIL rstmid outputs: got en=%b rd=%b wr=%b done=%b, required all 0",
                         fill_en, f_read_enable, f_write_enable, done);
    end
    repeat (3) @(negedge clk);
    @(posedge clk); #1 n_rst = 1'b1;
    rd_ptr = obs_n;
    checks++;
    if (done_seen != d0) begin errors++; $display("FAIL rstmid done: got %0d pulses, required 0", done_seen - d0); end
    test_partial(10, 20, 3, 3, 24'h00FF00);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    start = 1'b0; mem_busy = 1'b0;
    x0 = '0; x1 = '0; y0 = '0; y1 = '0; color = '0;
    test_reset;
    test_full_word;
    test_partial(10, 70, 2, 2, 24'h00FF00);
    test_backpressure;
    test_empty;
    test_partial(600, 1000, 5, 5, 24'h0A0B0C);
    test_partial(0, 63, 479, 500, 24'hC0FFEE);
    test_start_while_busy;
    test_reset_mid;
    checks++;
    if (both_seen != 0) begin errors++; $display("FAIL overlap: got %0d cycles with read and write, required 0", both_seen); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fill_engine.md
# fill_engine

Rectangle fill engine for the 2D GPU frame buffer. It takes a rectangle and a 24-bit colour, walks the covered SRAM words row by row, and issues read/write requests to the SRAM request multiplexer on its fill-side port. Fully covered words are written directly. Partially covered edge words use read-modify-write so that pixels outside the span are preserved. `fill_en` is the engine's busy flag, and it selects the fill port in that multiplexer.

## Interface
Parameters:
- `SCREEN_W`, 640, pixels per row
- `SCREEN_H`, 480, rows
- `PIX_PER_WORD`, 64, pixels per SRAM word
- `PIX_BITS`, 24, bits per pixel (RGB888)

Ports. Clock and reset: one clock, `clk`. Reset is `n_rst`, asynchronous and active-low.
- `clk`  in  1  system clock
- `n_rst`  in  1  async active-low reset
- `start`  in  1  single-cycle command strobe
- `x0`, `x1`  in  10 each  inclusive column bounds
- `y0`, `y1`  in  9 each  inclusive row bounds
- `color`  in  24  fill colour
- `mem_busy`  in  1  SRAM cannot accept a request this cycle
- `read_data`  in  1536  SRAM read word
- `read_valid`  in  1  `read_data` valid (single-cycle pulse)
- `fill_en`  out  1  engine busy; multiplexer select
- `f_read_enable`  out  1  read request
- `f_write_enable`  out  1  write request
- `f_address`  out  24  word address
- `f_write_data`  out  1536  write word
- `done`  out  1  one-cycle completion pulse

## Operation
- **Word layout.** Pixel `i` of a word occupies bits `[24*i+23 : 24*i]`.
- **Address.** `y*WORDS_PER_ROW + x/PIX_PER_WORD`, where `WORDS_PER_ROW = ceil(SCREEN_W/PIX_PER_WORD)` (10). Zero-extended to 24 bits.
- **Command capture.** `start` is sampled only in IDLE and is ignored while busy. `x0/x1/y0/y1/color` are registered on acceptance.
- **Clamping.** `x1 > SCREEN_W-1` clamps to `SCREEN_W-1`. `y1 > SCREEN_H-1` clamps to `SCREEN_H-1`.
- **Empty command.** If `x0 > x1`, `y0 > y1`, `x0 >= SCREEN_W` or `y0 >= SCREEN_H` after clamping: no memory access, and `done` pulses.
- **Per word.**
  - `lo` = `x0 % 64` if the word is the first word of the span, else 0.
  - `hi` = `x1 % 64` if the word is the last word of the span, else 63.
  - Full word (`lo==0` and `hi==63`): WRITE directly with `color` replicated across all pixels.
  - Otherwise: READ_REQ, then READ_WAIT, then WRITE with the merged word: `color` at pixels `lo..hi`, `read_data` elsewhere.
- **Traversal order.** Words left to right, then rows top to bottom.
- **FSM states:** IDLE, SETUP, READ_REQ, READ_WAIT, WRITE, ADVANCE, DONE.
  - IDLE → SETUP on accepted `start`.
  - SETUP → DONE if the command is empty. Otherwise → WRITE (full word) or READ_REQ (partial word).
  - READ_REQ → READ_WAIT when `mem_busy==0`.
  - READ_WAIT → WRITE on `read_valid`. The merged word is latched in that cycle.
  - WRITE → ADVANCE when `mem_busy==0`.
  - ADVANCE → WRITE or READ_REQ for the next word. → DONE after the last word of the last row.
  - DONE → IDLE.
- **Request hold.** While `mem_busy` is high, requests and their address/data are held stable.
- **One request at a time.** Read and write are never asserted together. At most one outstanding read.
- **Unexpected data.** `read_valid` outside READ_WAIT is ignored.

## Timing
- **Reset values.** All outputs 0. State IDLE. Command registers 0.
- **Reset mid-operation.** Immediate abort, no `done`, outputs 0 in the same cycle.
- **`fill_en`.** Rises the cycle after accepted `start`. Falls in the cycle after DONE, i.e. coincident with the return to IDLE.
- **`done`.** High for exactly the DONE cycle.
- **Request outputs.** `f_read_enable` / `f_write_enable` are registered outputs, high only in READ_REQ / WRITE respectively.
- **Full-word throughput.** 2 cycles per word (WRITE + ADVANCE), provided `mem_busy` stays low.
- **Partial-word throughput.** 3 cycles plus read latency.
- **Empty command latency.** `start` → `done` is 3 cycles (capture, SETUP, DONE).

## Structure
- **Shared package `gpu_pkg`:**
  - `fill_state_t` enum
  - `PIX_BITS`, `PIX_PER_WORD`, `WORD_BITS` (1536), `ADDR_BITS` (24), `WORDS_PER_ROW`
- **Sub-module `fill_merge`:** combinational; takes `lo`, `hi`, `color` and `read_data`, produces the merged 1536-bit word. It also serves the full-word case with `lo=0`, `hi=63`.

## Test plan
- **Full-word rectangle.** x0=0, x1=127, y0=y1=0, colour 0xFF0000 → writes at addresses 0 and 1 only, all pixels 0xFF0000, no reads, `done` once.
- **Partial edges.** x0=10, x1=70, y0=y1=2 → read/write at address 20, pixels 10..63 colour, pixels 0..9 unchanged. Then read/write at address 21, pixels 0..6 colour, pixels 7..63 unchanged.
- **Back-pressure.** `mem_busy` high for 5 cycles during WRITE → request, address and data held constant. Write issued on the first non-busy cycle.
- **Empty and clamped commands.** x0=20, x1=10 → `done` 3 cycles after `start`, no requests. x1=1000 → last write at column word 9.
- **Start while busy.** Second `start` mid-fill is ignored. Output is identical to the single-command run.
- **Reset mid-fill.** `n_rst` low during READ_WAIT → all outputs 0 immediately. A subsequent `start` completes normally.
